alarm_timekeeper: RTL
=====================

// Module: alarm_timekeeper
// PURPOSE
//  Parametrised timekeeping + multi-alarm core; successor to the fixed 12 h single-alarm clock logic.
//  Sits between the button debouncers (single-cycle pulses in) and the clock-face renderer / buzzer driver.
//  Adds N alarm channels, 12/24 h mode, snooze, ring timeout and carry-correct time fields (never out of range).
// PARAMETERS
//  CLK_HZ         31_500_000  video_clk cycles per second
//  TONE_HALF      5_000       buzzer tone half-period in cycles
//  NUM_ALARMS     2           alarm channels (1..8); AIDX_W = max(1,$clog2(NUM_ALARMS))
//  MODE_24H       0           0: hours 0..11 ; 1: hours 0..23
//  AL_MIN_STEP    10          minutes added per al_min_inc pulse
//  SNOOZE_MIN     5           snooze length in minutes
//  RING_TIMEOUT_S 60          auto-silence after this many seconds of ringing
// PORTS
//  video_clk   in   1           single clock, all state on rising edge
//  reset_n     in   1           asynchronous active-low reset
//  sec_inc     in   1           1-cycle pulse: seconds +1
//  min_inc     in   1           1-cycle pulse: minutes +1
//  hr_inc      in   1           1-cycle pulse: hours +1
//  al_idx      in   AIDX_W      alarm selected by al_* pulses
//  al_min_inc  in   1           1-cycle pulse: alarm[al_idx] minutes +AL_MIN_STEP
//  al_hr_inc   in   1           1-cycle pulse: alarm[al_idx] hours +1
//  al_toggle   in   1           1-cycle pulse: toggle al_on[al_idx]
//  snooze      in   1           1-cycle pulse: snooze all ringing channels
//  dismiss     in   1           1-cycle pulse: silence all ringing/snoozed channels
//  seconds     out  6           0..59
//  minutes     out  6           0..59
//  hours       out  5           0..11 or 0..23
//  al_minutes  out  6*NUM_ALARMS  packed, ch0 in LSBs
//  al_hours    out  5*NUM_ALARMS  packed, ch0 in LSBs
//  al_on       out  NUM_ALARMS  alarm enabled
//  ringing     out  NUM_ALARMS  channel in RING state
//  sec_tick    out  1           1-cycle pulse on each automatic second advance
//  half_sec    out  1           high while sub-second counter < CLK_HZ/2 (blink phase)
//  buzzer_out  out  1           gated tone
// BEHAVIOUR
//  Reset (async): all outputs 0, times 00:00:00, alarms 00:00, all channels IDLE, counters 0.
//  Cycle counter 0..CLK_HZ-1; on CLK_HZ-1 wraps to 0, sec_tick=1 that cycle (registered), time advances same edge.
//  Carry chain in one edge: 59s->0 + min carry; 59m->0 + hour carry; max hour->0. No transient 60/12/24.
//  Manual *_inc: +1 mod field range, no carry to next field.
//  sec_inc has priority: cycle counter cleared, seconds +1 once; coincident tick dropped (no sec_tick).
//  min_inc/hr_inc with automatic carry same cycle: field += carry + inc mod range; hour carry only from auto chain.
//  al_min_inc: +AL_MIN_STEP mod 60, no carry; al_hr_inc: +1 mod hour range; al_idx >= NUM_ALARMS: pulses ignored.
//  Per-channel FSM IDLE/RING/SNOOZE:
//   IDLE->RING: al_on && cycle after sec_tick with seconds==0 && hours/minutes == alarm time (manual setting never triggers).
//   RING->SNOOZE on snooze (load SNOOZE_MIN*60); RING->IDLE on dismiss or RING_TIMEOUT_S sec_ticks elapsed.
//   SNOOZE: counter -1 per sec_tick; reaching 0 -> RING (timeout reloaded). dismiss -> IDLE.
//   al_toggle on a channel in RING/SNOOZE: al_on=0, state IDLE. snooze+dismiss same cycle: dismiss wins.
//  ringing[i] = (state==RING), registered. Tone toggles every TONE_HALF cycles, free-running.
//  buzzer_out (registered) = |ringing & tone & half_sec: 1-cycle latency from inputs.
// TESTING (sim with CLK_HZ=100, TONE_HALF=5)
//  MODE_24H=0, set 11:59:59, one tick -> 00:00:00 on same edge as sec_tick; never 60 or 12 observed.
//  MODE_24H=1, 23:59:59 + tick -> 00:00:00; hr_inc from 11 -> 12; hr_inc from 23 -> 0 with minutes unchanged.
//  alarm0 01:10 on, run 01:09:59 -> ringing[0]=1 one cycle after tick; buzzer toggles per 5 cycles for 50 cycles, low next 50.
//  SNOOZE_MIN=1: snooze -> ringing 0 for exactly 60 sec_ticks then 1; dismiss -> 0, no retrigger in same minute.
//  No input while ringing: ringing drops after RING_TIMEOUT_S sec_ticks; ch1 at same time rings independently.
//  sec_inc on tick cycle -> seconds +1 only, sec_tick 0; reset_n low mid-ring -> buzzer_out/ringing 0 immediately.

Source files
------------

// File: rtl/alarm_timekeeper_if.sv
// rtl/alarm_timekeeper_if.sv - button pulses in, clock-face/alarm/buzzer state out
interface alarm_timekeeper_if #(
    parameter int NUM_ALARMS = 2,
    parameter int AIDX_W     = 1
);
    logic                    sec_inc;
    logic                    min_inc;
    logic                    hr_inc;
    logic [AIDX_W-1:0]       al_idx;
    logic                    al_min_inc;
    logic                    al_hr_inc;
    logic                    al_toggle;
    logic                    snooze;
    logic                    dismiss;
    logic [5:0]              seconds;
    logic [5:0]              minutes;
    logic [4:0]              hours;
    logic [6*NUM_ALARMS-1:0] al_minutes;
    logic [5*NUM_ALARMS-1:0] al_hours;
    logic [NUM_ALARMS-1:0]   al_on;
    logic [NUM_ALARMS-1:0]   ringing;
    logic                    sec_tick;
    logic                    half_sec;
    logic                    buzzer_out;

    modport master (
        output sec_inc, min_inc, hr_inc, al_idx, al_min_inc, al_hr_inc,
               al_toggle, snooze, dismiss,
        input  seconds, minutes, hours, al_minutes, al_hours, al_on,
               ringing, sec_tick, half_sec, buzzer_out
    );

    modport slave (
        input  sec_inc, min_inc, hr_inc, al_idx, al_min_inc, al_hr_inc,
               al_toggle, snooze, dismiss,
        output seconds, minutes, hours, al_minutes, al_hours, al_on,
               ringing, sec_tick, half_sec, buzzer_out
    );
endinterface

// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - carry-correct timekeeping with N alarm channels, snooze and ring timeout
module alarm_timekeeper #(
    parameter int CLK_HZ         = 31_500_000,
    parameter int TONE_HALF      = 5_000,
    parameter int NUM_ALARMS     = 2,
    parameter int MODE_24H       = 0,
    parameter int AL_MIN_STEP    = 10,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic              video_clk,
    input  logic              reset_n,
    alarm_timekeeper_if.slave bus
);
    localparam int AIDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int CYC_W       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int TONE_W      = (TONE_HALF > 2) ? $clog2(TONE_HALF) : 1;
    localparam int HR_MAX      = (MODE_24H != 0) ? 24 : 12;
    localparam int SNOOZE_LOAD = SNOOZE_MIN * 60;
    localparam int CNT_MAX     = (SNOOZE_LOAD > RING_TIMEOUT_S) ? SNOOZE_LOAD : RING_TIMEOUT_S;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

    logic [CYC_W-1:0]      r_cyc;
    logic [CYC_W-1:0]      w_cyc_next;
    logic                  r_sec_tick;
    logic                  r_half;
    logic [5:0]            r_sec;
    logic [5:0]            r_min;
    logic [4:0]            r_hr;
    logic                  w_tick;
    logic                  w_auto;
    logic                  w_min_carry;
    logic                  w_hr_carry;
    logic [6:0]            w_sec_sum;
    logic [6:0]            w_min_sum;
    logic [5:0]            w_hr_sum;
    logic                  w_idx_ok;
    logic [NUM_ALARMS-1:0] w_ringing;
    logic [NUM_ALARMS-1:0] w_al_on;
    logic [TONE_W-1:0]     r_tone_cnt;
    logic                  r_tone;
    logic                  r_buzz;

    // sec_inc wins over a coincident automatic tick: the tick is swallowed, not queued
    always_comb begin
        w_tick      = (r_cyc == CYC_W'(CLK_HZ - 1));
        w_auto      = w_tick && !bus.sec_inc;
        w_cyc_next  = (w_tick || bus.sec_inc) ? '0 : r_cyc + 1'b1;
        w_min_carry = w_auto && (r_sec == 6'd59);
        w_hr_carry  = w_min_carry && (r_min == 6'd59);
        w_sec_sum   = {1'b0, r_sec} + 7'(w_auto || bus.sec_inc);
        if (w_sec_sum >= 7'd60) w_sec_sum = w_sec_sum - 7'd60;
        w_min_sum   = {1'b0, r_min} + 7'(w_min_carry) + 7'(bus.min_inc);
        if (w_min_sum >= 7'd60) w_min_sum = w_min_sum - 7'd60;
        w_hr_sum    = {1'b0, r_hr} + 6'(w_hr_carry) + 6'(bus.hr_inc);
        if (w_hr_sum >= 6'(HR_MAX)) w_hr_sum = w_hr_sum - 6'(HR_MAX);
        w_idx_ok    = (int'(bus.al_idx) < NUM_ALARMS);
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc      <= '0;
            r_sec_tick <= 1'b0;
            r_half     <= 1'b0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hr       <= '0;
        end else begin
            r_cyc      <= w_cyc_next;
            r_sec_tick <= w_auto;
            r_half     <= (w_cyc_next < CYC_W'(CLK_HZ / 2));
            r_sec      <= w_sec_sum[5:0];
            r_min      <= w_min_sum[5:0];
            r_hr       <= w_hr_sum[4:0];
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_next;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic [5:0]       r_al_min;
        logic [4:0]       r_al_hr;
        logic             r_al_on;
        logic             w_sel;
        logic             w_toggle;
        logic             w_match;
        logic             w_ring;
        logic [6:0]       w_amin_sum;
        logic [5:0]       w_ahr_sum;

        always_comb begin
            w_sel      = w_idx_ok && (bus.al_idx == AIDX_W'(g));
            w_toggle   = w_sel && bus.al_toggle;
            w_amin_sum = {1'b0, r_al_min} + 7'(AL_MIN_STEP);
            if (w_amin_sum >= 7'd60) w_amin_sum = w_amin_sum - 7'd60;
            w_ahr_sum  = {1'b0, r_al_hr} + 6'd1;
            if (w_ahr_sum >= 6'(HR_MAX)) w_ahr_sum = '0;
            // only the automatic chain raises r_sec_tick, so manual edits cannot trigger
            w_match    = r_al_on && r_sec_tick && (r_sec == 6'd0) &&
                         (r_min == r_al_min) && (r_hr == r_al_hr);
        end

        always_ff @(posedge video_clk or negedge reset_n) begin
            if (!reset_n) begin
                r_al_min <= '0;
                r_al_hr  <= '0;
                r_al_on  <= 1'b0;
            end else begin
                if (w_sel && bus.al_min_inc) r_al_min <= w_amin_sum[5:0];
                if (w_sel && bus.al_hr_inc)  r_al_hr  <= w_ahr_sum[4:0];
                if (w_toggle) r_al_on <= (r_state == ST_IDLE) ? ~r_al_on : 1'b0;
            end
        end

        always_ff @(posedge video_clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        w_state_next = ST_RING;
                        w_cnt_next   = CNT_W'(RING_TIMEOUT_S);
                    end
                end
                ST_RING: begin
                    if (bus.dismiss || w_toggle) begin
                        w_state_next = ST_IDLE;
                    end else if (bus.snooze) begin
                        w_state_next = ST_SNOOZE;
                        w_cnt_next   = CNT_W'(SNOOZE_LOAD);
                    end else if (r_sec_tick) begin
                        if (r_cnt <= CNT_W'(1)) w_state_next = ST_IDLE;
                        else                    w_cnt_next   = r_cnt - 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (bus.dismiss || w_toggle) begin
                        w_state_next = ST_IDLE;
                    end else if (r_sec_tick) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            w_state_next = ST_RING;
                            w_cnt_next   = CNT_W'(RING_TIMEOUT_S);
                        end else begin
                            w_cnt_next   = r_cnt - 1'b1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        always_comb begin
            w_ring = (r_state == ST_RING);
        end

        assign w_ringing[g]              = w_ring;
        assign w_al_on[g]                = r_al_on;
        assign bus.al_minutes[6*g +: 6]  = r_al_min;
        assign bus.al_hours[5*g +: 5]    = r_al_hr;
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_buzz     <= 1'b0;
        end else begin
            if (r_tone_cnt == TONE_W'(TONE_HALF - 1)) begin
                r_tone_cnt <= '0;
                r_tone     <= ~r_tone;
            end else begin
                r_tone_cnt <= r_tone_cnt + 1'b1;
            end
            r_buzz <= (|w_ringing) && r_tone && r_half;
        end
    end

    assign bus.seconds    = r_sec;
    assign bus.minutes    = r_min;
    assign bus.hours      = r_hr;
    assign bus.al_on      = w_al_on;
    assign bus.ringing    = w_ringing;
    assign bus.sec_tick   = r_sec_tick;
    assign bus.half_sec   = r_half;
    assign bus.buzzer_out = r_buzz;
endmodule
